// File: rtl/star_softmax_ctrl.sv
// Sequencer for the STAR CAM/LUT softmax datapath.
// Per row: fetch INPUT_LEN scores and stream them to the CAM-subtract memory
// while tracking the one-hot row max, then run the find-subtract burst and the
// exponent-lookup burst. Each phase lasts INPUT_LEN+1 cycles.
// Build option: define STAR_ROW_LOOP_EN to process all N_ROWS rows; when it is
// left undefined only row 0 is processed before finish.
module star_softmax_ctrl #(
  parameter int INPUT_LEN = 16,
  parameter int N_ROWS    = 16,
  parameter int LUT_LEN   = 64,
  parameter int DATA_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] data,
  output logic                     data_req,
  output logic [8:0]               data_addr,
  output logic signed [DATA_W-1:0] xi,
  output logic                     CAMSUB_req,
  input  logic [LUT_LEN-1:0]       i_xi_MV,
  output logic [LUT_LEN-1:0]       o_xi_MV,
  output logic [LUT_LEN-1:0]       o_xmax_MV,
  output logic                     FindSub_req,
  input  logic [LUT_LEN-1:0]       i_sub_MV,
  output logic                     EXP_req,
  output logic [LUT_LEN-1:0]       o_sub_MV,
  input  logic [31:0]              exp,
  input  logic [31:0]              Sum_exp,
  output logic                     finish
);

  localparam int ADDR_W = 9;
  localparam int CNT_W  = $clog2(INPUT_LEN + 1);
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, FINDSUB, EXP, DONE} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [ROW_W-1:0]          row;
  logic                      phase_end;
  logic                      last_row;
  logic                      load_entry;
  logic [ADDR_W-1:0]         addr_issue;
  logic [ADDR_W-1:0]         addr_q;
  logic                      camsub_vld_p1;
  logic signed [DATA_W-1:0]  xi_p1;
  logic [31:0]               exp_acc;

  assign phase_end  = (cnt == CNT_W'(INPUT_LEN));
  assign addr_issue = ADDR_W'(row) * ADDR_W'(INPUT_LEN) + ADDR_W'(cnt);
  assign load_entry = (state_nxt == LOAD) && (state != LOAD);

`ifdef STAR_ROW_LOOP_EN
  assign last_row = (row == ROW_W'(N_ROWS - 1));
`else
  assign last_row = 1'b1;
`endif

  // Phase state, per-phase cycle counter and row index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (state == LOAD || state == FINDSUB || state == EXP)
        cnt <= cnt + 1'b1;
      if (state == EXP && phase_end && !last_row)
        row <= row + 1'b1;
    end
  end

  // Next-state decode and phase request strobes.
  always_comb begin
    state_nxt   = state;
    data_req    = 1'b0;
    FindSub_req = 1'b0;
    EXP_req     = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE:    state_nxt = LOAD;
      LOAD: begin
        data_req = (cnt < CNT_W'(INPUT_LEN));
        if (phase_end) state_nxt = FINDSUB;
      end
      FINDSUB: begin
        FindSub_req = 1'b1;
        if (phase_end) state_nxt = EXP;
      end
      EXP: begin
        EXP_req = 1'b1;
        if (phase_end) state_nxt = last_row ? DONE : LOAD;
      end
      DONE:    finish = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // Address holds the last issued fetch once the fetch burst is over.
  assign data_addr  = data_req ? addr_issue : addr_q;
  assign xi         = xi_p1;
  assign CAMSUB_req = camsub_vld_p1;

  // Score capture, match-vector capture, row max and exponent accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      camsub_vld_p1 <= 1'b0;
      xi_p1         <= '0;
      o_xi_MV       <= '0;
      o_xmax_MV     <= '0;
      o_sub_MV      <= '0;
      exp_acc       <= '0;
    end else begin
      if (data_req) addr_q <= addr_issue;
      // stage p0 -> p1: fetched score becomes xi, valid follows one cycle later
      camsub_vld_p1 <= data_req;
      if (data_req) xi_p1 <= data;
      // stage p1 -> p2: CAMSUB memory returns the one-hot code of xi
      if (camsub_vld_p1) o_xi_MV <= i_xi_MV;
      if (load_entry)
        o_xmax_MV <= '0;
      else if (camsub_vld_p1 && (i_xi_MV > o_xmax_MV))
        o_xmax_MV <= i_xi_MV;
      // exponent phase: register the subtract code toward the LUT
      if (state == EXP) o_sub_MV <= i_sub_MV;
      if (load_entry)
        exp_acc <= '0;
      else if (state == EXP && o_sub_MV != '0)
        exp_acc <= exp_acc + exp;
    end
  end

endmodule

// File: tb/tb_star_softmax_ctrl.sv
// Scoreboard bench for star_softmax_ctrl: a memory model serves score fetches
// and returns one-hot match vectors; expected addresses, scores and row maxima
// come from a row-level model of the score memory.
module tb_star_softmax_ctrl;

  localparam int IL = 16;
  localparam int NR = 16;
  localparam int LL = 64;
`ifdef STAR_ROW_LOOP_EN
  localparam int ROWS_RUN = NR;
`else
  localparam int ROWS_RUN = 1;
`endif
  localparam int ROW_CYC  = 3 * (IL + 1);
  localparam int FS_TARGET = (ROWS_RUN >= 4) ? 4 : 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] data;
  logic              data_req;
  logic [8:0]        data_addr;
  logic signed [7:0] xi;
  logic              CAMSUB_req;
  logic [LL-1:0]     i_xi_MV;
  logic [LL-1:0]     o_xi_MV;
  logic [LL-1:0]     o_xmax_MV;
  logic              FindSub_req;
  logic [LL-1:0]     i_sub_MV;
  logic              EXP_req;
  logic [LL-1:0]     o_sub_MV;
  logic [31:0]       exp_v;
  logic [31:0]       sum_v;
  logic              finish;

  star_softmax_ctrl #(.INPUT_LEN(IL), .N_ROWS(NR), .LUT_LEN(LL)) dut (
    .clk(clk), .rst(rst), .data(data), .data_req(data_req), .data_addr(data_addr),
    .xi(xi), .CAMSUB_req(CAMSUB_req), .i_xi_MV(i_xi_MV), .o_xi_MV(o_xi_MV),
    .o_xmax_MV(o_xmax_MV), .FindSub_req(FindSub_req), .i_sub_MV(i_sub_MV),
    .EXP_req(EXP_req), .o_sub_MV(o_sub_MV), .exp(exp_v), .Sum_exp(sum_v),
    .finish(finish)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int fs_rises = 0;

  logic signed [7:0] mem [0:255];
  int                addr_q [$];
  logic signed [7:0] xi_q   [$];
  int                max_q  [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Expected fetch order and per-row maxima straight from the score memory.
  task automatic build_model();
    int m;
    addr_q.delete();
    xi_q.delete();
    max_q.delete();
    for (int r = 0; r < ROWS_RUN; r++) begin
      m = -128;
      for (int k = 0; k < IL; k++) begin
        addr_q.push_back(r * IL + k);
        if (int'(mem[r * IL + k]) > m) m = int'(mem[r * IL + k]);
      end
      max_q.push_back(m);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_xi"}, 64'(xi), 64'd0);
    check({tag, "_addr"}, 64'(data_addr), 64'd0);
    check({tag, "_data_req"}, 64'(data_req), 64'd0);
    check({tag, "_camsub_req"}, 64'(CAMSUB_req), 64'd0);
    check({tag, "_findsub_req"}, 64'(FindSub_req), 64'd0);
    check({tag, "_exp_req"}, 64'(EXP_req), 64'd0);
    check({tag, "_finish"}, 64'(finish), 64'd0);
    check({tag, "_o_xi_MV"}, o_xi_MV, 64'd0);
    check({tag, "_o_xmax_MV"}, o_xmax_MV, 64'd0);
    check({tag, "_o_sub_MV"}, o_sub_MV, 64'd0);
  endtask

  task automatic run_to_finish(input string tag);
    int i;
    for (i = 0; i < 3000 && !finish; i++) @(posedge clk);
    #3;
    check({tag, "_finish_seen"}, 64'(finish), 64'd1);
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #3;
      check({tag, "_finish_hold"}, 64'(finish), 64'd1);
      check({tag, "_done_reqs"}, 64'({data_req, CAMSUB_req, FindSub_req, EXP_req}), 64'd0);
      check({tag, "_done_addr"}, 64'(data_addr), 64'(ROWS_RUN * IL - 1));
    end
    check({tag, "_addr_q_empty"}, 64'(addr_q.size()), 64'd0);
    check({tag, "_xi_q_empty"}, 64'(xi_q.size()), 64'd0);
    check({tag, "_max_q_empty"}, 64'(max_q.size()), 64'd0);
  endtask

  // Memory model: serve the fetched score on the falling edge and return
  // the one-hot code of whatever xi the DUT is presenting.
  always @(negedge clk) begin
    if (!rst && data_req) begin
      data = mem[int'(data_addr)];
      xi_q.push_back(mem[int'(data_addr)]);
    end
    i_xi_MV  = CAMSUB_req ? (64'd1 << (int'(xi) + 20)) : 64'd0;
    i_sub_MV = {$urandom, $urandom};
    exp_v    = $urandom;
    sum_v    = $urandom;
  end

  // Monitor: sample just after each rising edge and compare with the scoreboard.
  int          cyc = 0;
  logic        p_data_req, p_camsub, p_findsub, p_exp, p_finish;
  logic signed [7:0] p_xi;
  logic [3:0]  p_req;
  int          run_len [4];
  int          exp_len [4] = '{IL + 1, IL + 1, IL, IL};
  string       req_name [4] = '{"exp_req_len", "findsub_req_len", "camsub_req_len", "data_req_len"};

  always @(posedge clk) begin : monitor
    logic [3:0]        req_now;
    int                m;
    logic signed [7:0] xe;
    #1;
    if (rst) begin
      cyc = 0;
      p_data_req = 0; p_camsub = 0; p_findsub = 0; p_exp = 0; p_finish = 0;
      p_xi = 0; p_req = 0;
      for (int i = 0; i < 4; i++) run_len[i] = 0;
    end else begin
      cyc++;
      if (cyc == 1) check("first_fetch", 64'({data_req, data_addr}), 64'({1'b1, 9'd0}));
      if (data_req) begin
        if (addr_q.size() == 0) check("addr_unexpected", 64'(data_addr), 64'h1ff);
        else check("data_addr", 64'(data_addr), 64'(addr_q.pop_front()));
      end
      check("camsub_lag", 64'(CAMSUB_req), 64'(p_data_req));
      if (CAMSUB_req) begin
        if (xi_q.size() == 0) check("xi_unexpected", 64'(xi), 64'h1ff);
        else begin
          xe = xi_q.pop_front();
          check("xi", 64'(xi), 64'(xe));
        end
      end
      if (p_camsub) check("o_xi_MV", o_xi_MV, 64'd1 << (int'(p_xi) + 20));
      if (data_req && !p_data_req) check("xmax_clear", o_xmax_MV, 64'd0);
      if (FindSub_req && !p_findsub) begin
        fs_rises++;
        if (max_q.size() == 0) check("xmax_unexpected", o_xmax_MV, 64'd0 - 1);
        else begin
          m = max_q.pop_front();
          check("o_xmax_MV", o_xmax_MV, 64'd1 << (m + 20));
        end
      end
      if (p_exp) check("o_sub_MV", o_sub_MV, i_sub_MV);
      check("req_exclusive",
            64'((int'(FindSub_req) + int'(EXP_req) + int'(data_req | CAMSUB_req)) <= 1), 64'd1);
      req_now = {data_req, CAMSUB_req, FindSub_req, EXP_req};
      for (int i = 0; i < 4; i++) begin
        if (req_now[i]) run_len[i]++;
        else if (p_req[i]) begin
          check(req_name[i], 64'(run_len[i]), 64'(exp_len[i]));
          run_len[i] = 0;
        end
      end
      if (finish && !p_finish) check("finish_cycle", 64'(cyc), 64'(1 + ROWS_RUN * ROW_CYC));
      p_data_req = data_req; p_camsub = CAMSUB_req; p_findsub = FindSub_req;
      p_exp = EXP_req; p_finish = finish; p_xi = xi; p_req = req_now;
    end
  end

  initial begin
    int perm [IL];
    int t, j, pos;
    data = 0; i_xi_MV = 0; i_sub_MV = 0; exp_v = 0; sum_v = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(int'($urandom_range(63, 0)) - 20);
    // Row 0: every score in -20..-5 exactly once, shuffled.
    for (int i = 0; i < IL; i++) perm[i] = i;
    for (int i = IL - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < IL; i++) mem[i] = 8'(perm[i] - 20);
    build_model();

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Run until the chosen row reaches its find-subtract phase, then reset mid-run.
    for (int i = 0; i < 3000 && fs_rises < FS_TARGET; i++) @(posedge clk);
    check("reach_findsub", 64'(fs_rises >= FS_TARGET), 64'd1);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrun_rst");
    repeat (2) @(posedge clk);
    #3;
    fs_rises = 0;
    build_model();
    rst = 1'b0;
    run_to_finish("run1");

    // Second run: row 0 holds the max 43 at a random position.
    #1;
    rst = 1'b1;
    for (int i = 0; i < IL; i++) mem[i] = 8'(int'($urandom_range(62, 0)) - 20);
    pos = int'($urandom_range(IL - 1, 0));
    mem[pos] = 8'sd43;
    build_model();
    repeat (2) @(posedge clk);
    #3;
    check_reset_outputs("reset2");
    rst = 1'b0;
    run_to_finish("run2");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
